// File: rtl/multicycle_ctrl.sv
// Purpose: phase sequencer (IF/ID/EX/MEM/WB) for the multi-cycle CPU; gates decoder enables per phase and counts retired instructions.
// Latency: zero-wait memory gives branch/jump 3, ALU/jal/store 4, load 5 cycles; each memory wait cycle adds one.
// Backpressure: imemReq/dmemReq are held in their phase until the matching ready is sampled; run=0 only blocks a new fetch.
//
// Ports:
//   clk, rstn                  rising-edge clock, asynchronous active-low reset
//   run                        level enable for starting a new fetch
//   imemReady, dmemReady       memory completion handshakes
//   ctrlRegWrite/MemRead/MemWrite/NPCFrom   static decode enables, stable from ID until next IF
//   imemReq, irWrite           fetch request and instruction-register capture
//   dmemReq, dmemWe, mdrWrite  data access request, write qualifier, memory-data-register capture
//   regWriteEn, pcWrite        register-file write and PC update strobes
//   phase                      current phase encoding (0..4)
//   instret                    retired-instruction counter, wraps modulo 2^CNT_W
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             run,
    input  logic             imemReady,
    input  logic             dmemReady,
    input  logic             ctrlRegWrite,
    input  logic             ctrlMemRead,
    input  logic             ctrlMemWrite,
    input  logic [1:0]       ctrlNPCFrom,
    output logic             imemReq,
    output logic             irWrite,
    output logic             dmemReq,
    output logic             dmemWe,
    output logic             mdrWrite,
    output logic             regWriteEn,
    output logic             pcWrite,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        PH_IF  = 3'd0,
        PH_ID  = 3'd1,
        PH_EX  = 3'd2,
        PH_MEM = 3'd3,
        PH_WB  = 3'd4
    } phase_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    phase_e           r_phase;
    phase_e           w_phase_nxt;
    logic             w_retire;
    logic [CNT_W-1:0] r_instret;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_phase   <= PH_IF;
            r_instret <= '0;
        end else begin
            r_phase <= w_phase_nxt;
            if (w_retire) begin
                r_instret <= r_instret + CNT_ONE;
            end
        end
    end

    // Every instruction retires on the same cycle its pcWrite fires, so the
    // counter increment is tied to that strobe.
    assign w_retire = pcWrite;

    always_comb begin
        w_phase_nxt = r_phase;
        imemReq     = 1'b0;
        irWrite     = 1'b0;
        dmemReq     = 1'b0;
        dmemWe      = 1'b0;
        mdrWrite    = 1'b0;
        regWriteEn  = 1'b0;
        pcWrite     = 1'b0;

        case (r_phase)
            PH_IF: begin
                // Request follows run directly; dropping run parks the
                // sequencer here without a state change.
                imemReq = run;
                if (run && imemReady) begin
                    irWrite     = 1'b1;
                    w_phase_nxt = PH_ID;
                end
            end
            PH_ID: begin
                w_phase_nxt = PH_EX;
            end
            PH_EX: begin
                if (ctrlMemRead || ctrlMemWrite) begin
                    w_phase_nxt = PH_MEM;
                end else if ((ctrlNPCFrom != 2'b00) && !ctrlRegWrite) begin
                    // Branches and non-linking jumps finish here.
                    pcWrite     = 1'b1;
                    w_phase_nxt = PH_IF;
                end else begin
                    w_phase_nxt = PH_WB;
                end
            end
            PH_MEM: begin
                dmemReq = 1'b1;
                // A malformed read+write decode is treated as a store.
                dmemWe  = ctrlMemWrite;
                if (dmemReady) begin
                    if (ctrlMemWrite) begin
                        pcWrite     = 1'b1;
                        w_phase_nxt = PH_IF;
                    end else begin
                        mdrWrite    = 1'b1;
                        w_phase_nxt = PH_WB;
                    end
                end
            end
            PH_WB: begin
                // Unknown opcodes arrive with ctrlRegWrite low and retire as NOPs.
                regWriteEn  = ctrlRegWrite;
                pcWrite     = 1'b1;
                w_phase_nxt = PH_IF;
            end
            default: begin
                // Unused encodings recover to IF with all strobes quiet.
                w_phase_nxt = PH_IF;
            end
        endcase
    end

    assign phase   = r_phase;
    assign instret = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Purpose: directed, table-driven bench for the multi-cycle phase sequencer.
// Latency: inputs change just after the falling edge, outputs sampled 1 time unit later.
// Backpressure: memory ready lines are driven per cycle from the vector table.
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic             run;
    logic             imemReady;
    logic             dmemReady;
    logic             ctrlRegWrite;
    logic             ctrlMemRead;
    logic             ctrlMemWrite;
    logic [1:0]       ctrlNPCFrom;
    logic             imemReq;
    logic             irWrite;
    logic             dmemReq;
    logic             dmemWe;
    logic             mdrWrite;
    logic             regWriteEn;
    logic             pcWrite;
    logic [2:0]       phase;
    logic [CNT_W-1:0] instret;

    int checks   = 0;
    int failures = 0;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .run          (run),
        .imemReady    (imemReady),
        .dmemReady    (dmemReady),
        .ctrlRegWrite (ctrlRegWrite),
        .ctrlMemRead  (ctrlMemRead),
        .ctrlMemWrite (ctrlMemWrite),
        .ctrlNPCFrom  (ctrlNPCFrom),
        .imemReq      (imemReq),
        .irWrite      (irWrite),
        .dmemReq      (dmemReq),
        .dmemWe       (dmemWe),
        .mdrWrite     (mdrWrite),
        .regWriteEn   (regWriteEn),
        .pcWrite      (pcWrite),
        .phase        (phase),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    // Observed output bundle: {imemReq, irWrite, dmemReq, dmemWe, mdrWrite, regWriteEn, pcWrite, phase[2:0]}
    logic [9:0] obs;
    assign obs = {imemReq, irWrite, dmemReq, dmemWe, mdrWrite, regWriteEn, pcWrite, phase};

    // Input bundle: {run, imemReady, dmemReady, ctrlRegWrite, ctrlMemRead, ctrlMemWrite, ctrlNPCFrom[1:0]}
    typedef struct packed {
        logic [7:0] in;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [7:0] in, input logic [9:0] exp);
        vec_t v;
        v.in  = in;
        v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs after the falling edge; outputs settle 1 unit later.
    task automatic drive(input logic [7:0] v);
        @(negedge clk);
        {run, imemReady, dmemReady, ctrlRegWrite, ctrlMemRead, ctrlMemWrite, ctrlNPCFrom} = v;
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        {run, imemReady, dmemReady, ctrlRegWrite, ctrlMemRead, ctrlMemWrite, ctrlNPCFrom} = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        // addu, zero-wait
        tbl.push_back(mk(8'b1_1_0_1_0_0_00, 10'b1_1_0_0_0_0_0_000));
        tbl.push_back(mk(8'b1_0_0_1_0_0_00, 10'b0_0_0_0_0_0_0_001));
        tbl.push_back(mk(8'b1_0_0_1_0_0_00, 10'b0_0_0_0_0_0_0_010));
        tbl.push_back(mk(8'b1_0_0_1_0_0_00, 10'b0_0_0_0_0_1_1_100));
        // lw: imemReady late by 2, stray dmemReady in ID, dmemReady late by 1
        tbl.push_back(mk(8'b1_0_0_1_1_0_00, 10'b1_0_0_0_0_0_0_000));
        tbl.push_back(mk(8'b1_0_0_1_1_0_00, 10'b1_0_0_0_0_0_0_000));
        tbl.push_back(mk(8'b1_1_0_1_1_0_00, 10'b1_1_0_0_0_0_0_000));
        tbl.push_back(mk(8'b1_0_1_1_1_0_00, 10'b0_0_0_0_0_0_0_001));
        tbl.push_back(mk(8'b1_0_0_1_1_0_00, 10'b0_0_0_0_0_0_0_010));
        tbl.push_back(mk(8'b1_0_0_1_1_0_00, 10'b0_0_1_0_0_0_0_011));
        tbl.push_back(mk(8'b1_0_1_1_1_0_00, 10'b0_0_1_0_1_0_0_011));
        tbl.push_back(mk(8'b1_0_0_1_1_0_00, 10'b0_0_0_0_0_1_1_100));
        // sw, zero-wait
        tbl.push_back(mk(8'b1_1_0_0_0_1_00, 10'b1_1_0_0_0_0_0_000));
        tbl.push_back(mk(8'b1_0_0_0_0_1_00, 10'b0_0_0_0_0_0_0_001));
        tbl.push_back(mk(8'b1_0_0_0_0_1_00, 10'b0_0_0_0_0_0_0_010));
        tbl.push_back(mk(8'b1_0_1_0_0_1_00, 10'b0_0_1_1_0_0_1_011));
        // beq
        tbl.push_back(mk(8'b1_1_0_0_0_0_01, 10'b1_1_0_0_0_0_0_000));
        tbl.push_back(mk(8'b1_0_0_0_0_0_01, 10'b0_0_0_0_0_0_0_001));
        tbl.push_back(mk(8'b1_0_0_0_0_0_01, 10'b0_0_0_0_0_0_1_010));
        // jal
        tbl.push_back(mk(8'b1_1_0_1_0_0_10, 10'b1_1_0_0_0_0_0_000));
        tbl.push_back(mk(8'b1_0_0_1_0_0_10, 10'b0_0_0_0_0_0_0_001));
        tbl.push_back(mk(8'b1_0_0_1_0_0_10, 10'b0_0_0_0_0_0_0_010));
        tbl.push_back(mk(8'b1_0_0_1_0_0_10, 10'b0_0_0_0_0_1_1_100));
        // read+write decode: write wins, no mdrWrite
        tbl.push_back(mk(8'b1_1_0_0_1_1_00, 10'b1_1_0_0_0_0_0_000));
        tbl.push_back(mk(8'b1_0_0_0_1_1_00, 10'b0_0_0_0_0_0_0_001));
        tbl.push_back(mk(8'b1_0_0_0_1_1_00, 10'b0_0_0_0_0_0_0_010));
        tbl.push_back(mk(8'b1_0_1_0_1_1_00, 10'b0_0_1_1_0_0_1_011));
        // run low in IF: no request even with ready high
        tbl.push_back(mk(8'b0_1_1_0_0_0_00, 10'b0_0_0_0_0_0_0_000));
        tbl.push_back(mk(8'b0_1_1_0_0_0_00, 10'b0_0_0_0_0_0_0_000));

        // Reset state
        rstn = 1'b0;
        {run, imemReady, dmemReady, ctrlRegWrite, ctrlMemRead, ctrlMemWrite, ctrlNPCFrom} = '0;
        #2;
        chk("reset_outputs", 32'(obs), 32'd0);
        chk("reset_instret", 32'(instret), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].in);
            chk($sformatf("vec[%0d]", i), 32'(obs), 32'(tbl[i].exp));
        end
        chk("instret_after_table", 32'(instret), 32'd6);

        // Reset pulsed while a load waits in MEM
        drive(8'b1_1_0_1_1_0_00);
        drive(8'b0_0_0_1_1_0_00);
        drive(8'b0_0_0_1_1_0_00);
        drive(8'b0_0_0_1_1_0_00);
        chk("mem_wait_dmemReq", 32'(dmemReq), 32'd1);
        chk("mem_wait_phase", 32'(phase), 32'd3);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_phase", 32'(phase), 32'd0);
        chk("async_rst_instret", 32'(instret), 32'd0);
        chk("async_rst_outputs", 32'(obs), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(8'b0_0_1_1_1_0_00);
            chk($sformatf("post_rst_idle[%0d]", i), 32'(obs), 32'd0);
        end
        chk("post_rst_instret", 32'(instret), 32'd0);

        // run dropped during ID: in-flight NOP retires, next IF parks
        drive(8'b1_1_0_0_0_0_00);
        chk("runlow_if_irWrite", 32'(irWrite), 32'd1);
        drive(8'b0_0_0_0_0_0_00);
        chk("runlow_id_phase", 32'(phase), 32'd1);
        drive(8'b0_0_0_0_0_0_00);
        chk("runlow_ex_phase", 32'(phase), 32'd2);
        drive(8'b0_0_0_0_0_0_00);
        chk("runlow_wb", 32'(obs), 32'(10'b0_0_0_0_0_0_1_100));
        for (int i = 0; i < 3; i++) begin
            drive(8'b0_1_0_0_0_0_00);
            chk($sformatf("runlow_park[%0d]", i), 32'(obs), 32'd0);
        end
        chk("runlow_instret", 32'(instret), 32'd1);
        drive(8'b1_0_0_0_0_0_00);
        chk("run_back_imemReq", 32'(obs), 32'(10'b1_0_0_0_0_0_0_000));

        // 17 back-to-back NOPs from reset; counter wraps at 16
        do_reset();
        for (int n = 1; n <= 17; n++) begin
            for (int c = 0; c < 4; c++) begin
                drive(8'b1_1_0_0_0_0_00);
                if (c == 0 && n >= 16) begin
                    chk($sformatf("wrap_instret_n%0d", n - 1), 32'(instret), 32'((n - 1) % 16));
                end
                chk($sformatf("nop%0d_c%0d_pcWrite", n, c), 32'(pcWrite), (c == 3) ? 32'd1 : 32'd0);
                chk($sformatf("nop%0d_c%0d_phase", n, c), 32'(phase), (c == 3) ? 32'd4 : 32'(c));
            end
        end
        drive(8'b0_0_0_0_0_0_00);
        chk("wrap_instret_n17", 32'(instret), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Phase sequencer for the multi-cycle build of the CPU. Steps each instruction through the IF, ID, EX, MEM and WB phases.
- Handles the instruction-memory and data-memory ready handshakes.
- Gates the static decode enables from the main decoder (ctrlRegWrite, ctrlMemRead, ctrlMemWrite, ctrlNPCFrom) so that each takes effect only in its own phase.
- Counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  system clock, rising-edge.
rstn  input  1  reset, asynchronous, active-low.
run  input  1  level; when 0, no new fetch starts. An instruction already in flight completes.
imemReady  input  1  instruction memory has the word this cycle.
dmemReady  input  1  data memory access completes this cycle.
ctrlRegWrite  input  1  decoder: instruction writes the register file.
ctrlMemRead  input  1  decoder: load.
ctrlMemWrite  input  1  decoder: store.
ctrlNPCFrom  input  2  decoder: 00 = PC+4, otherwise branch/jump/jr.
imemReq  output  1  instruction fetch request.
irWrite  output  1  capture the instruction register.
dmemReq  output  1  data access request.
dmemWe  output  1  data access is a write; valid only with dmemReq.
mdrWrite  output  1  capture the memory data register.
regWriteEn  output  1  register-file write strobe.
pcWrite  output  1  PC update strobe; the NPC mux selects the source.
phase  output  3  current state: 0 = IF, 1 = ID, 2 = EX, 3 = MEM, 4 = WB.
instret  output  CNT_W  count of retired instructions.

Behaviour:
- Reset (rstn low, takes effect immediately):
  - phase = IF, instret = 0.
  - The outputs are a combinational decode of phase and inputs. While reset is held with run = 0, every strobe is 0.
  - Reset mid-instruction abandons it. There is no pcWrite and no regWriteEn, and instret does not increment.
  - On rstn deassertion, fetching starts on the next cycle in which run = 1.
- Handshake:
  - A request stays high in every cycle of its phase until the matching ready is sampled high.
  - The transfer completes on the rising edge where req and ready are both 1.
  - A ready pulse while the request is low is ignored. Zero-wait memory, meaning ready is 1 in the first request cycle, gives a 1-cycle phase.
- IF:
  - imemReq = run.
  - On imemReady & run: irWrite = 1 and go to ID. Otherwise stay in IF.
  - If run drops while in IF, the request drops and no state change occurs.
- ID: 1 cycle, no strobes, then EX. The decoder outputs are valid from ID onward and are held stable until the next IF.
- EX (1 cycle); the first matching rule applies:
  - ctrlMemRead or ctrlMemWrite → MEM.
  - ctrlNPCFrom != 0 and ctrlRegWrite = 0 (beq, bne, j, jr) → pcWrite = 1, instret += 1, go to IF.
  - Otherwise (R-type, immediate ops, jal, unknown opcode) → WB.
- MEM:
  - dmemReq = 1 and dmemWe = ctrlMemWrite.
  - If ctrlMemRead and ctrlMemWrite are both 1, the write wins.
  - On dmemReady, store: pcWrite = 1, instret += 1, go to IF.
  - On dmemReady, load: mdrWrite = 1, go to WB.
- WB:
  - regWriteEn = ctrlRegWrite; an unknown opcode therefore retires as a NOP.
  - pcWrite = 1, instret += 1, go to IF.
- Strobe exclusivity:
  - pcWrite, irWrite, regWriteEn and mdrWrite are each high for exactly 1 cycle per instruction, and only when that strobe applies to the instruction.
  - imemReq and dmemReq are never high together.
- Latency with zero-wait memory: branches/jumps 3 cycles; ALU ops and jal 4 cycles; stores 4 cycles; loads 5 cycles. Each memory wait cycle adds 1 cycle.
- instret wraps modulo 2^CNT_W with no saturation.
- Illegal phase encodings 5-7 return to IF on the next clock with no strobes asserted.

Test Plan:
- addu, zero-wait memory, run = 1 → phase 0, 1, 2, 4. irWrite in cycle 1; regWriteEn and pcWrite together in cycle 4; instret 0 → 1.
- lw with imemReady delayed 2 cycles and dmemReady delayed 1 cycle → imemReq high for 3 cycles, dmemReq high for 2 cycles with dmemWe = 0. mdrWrite, then regWriteEn; total 8 cycles.
- sw, zero-wait → dmemReq = 1 and dmemWe = 1 in cycle 4 together with pcWrite. No regWriteEn; phase returns to IF.
- beq (ctrlNPCFrom = 01) then jal (ctrlNPCFrom = 10, ctrlRegWrite = 1) → beq: pcWrite in EX at cycle 3. jal: EX→WB, regWriteEn + pcWrite at cycle 4. instret = 2.
- rstn pulsed low in MEM while dmemReq is high → asynchronous return to phase 0, instret = 0, strobes low with no clock edge needed. No pcWrite; a dmemReady arriving afterwards is ignored.
- CNT_W = 4, 17 back-to-back NOPs; separately, run dropped during ID → instret reads 15, 0, 1. The in-flight instruction retires and the next IF holds imemReq = 0 until run returns.
